// File: rtl/axi_read_intf_if.sv
// AXI read address / read data channel bundle shared by the read slave and
// its master. Signal names follow the AXI channel naming used by the ports.
interface axi_read_intf_if #(
  parameter int ARID_WIDTH   = 8,
  parameter int ARADDR_WIDTH = 11,
  parameter int RDATA_WIDTH  = 32
);
  logic [ARID_WIDTH-1:0]   ARID;
  logic [ARADDR_WIDTH-1:0] ARADDR;
  logic [7:0]              ARLEN;
  logic [2:0]              ARSIZE;
  logic [2:0]              ARBURST;
  logic [3:0]              ARREGION;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [ARID_WIDTH-1:0]   RID;
  logic [RDATA_WIDTH-1:0]  RDATA;
  logic [1:0]              RRESP;
  logic                    RLAST;
  logic                    RVALID;
  logic                    RREADY;

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARREGION, ARVALID, RREADY,
    output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARREGION, ARVALID, RREADY,
    input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/axi_read_intf.sv
// AXI read-channel slave. Accepts one AR burst at a time, issues one
// single-cycle internal read request per beat and returns each result on the
// R channel. Illegal size/burst encodings are answered with SLVERR beats
// without touching the internal bus.
module axi_read_intf #(
  parameter int ARID_WIDTH   = 8,
  parameter int ARADDR_WIDTH = 11,
  parameter int RDATA_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  axi_read_intf_if.slave          axi,
  output logic                    axi_rd_req,
  output logic [ARADDR_WIDTH-1:0] axi_rd_addr,
  output logic [1:0]              axi_rd_region,
  input  logic [RDATA_WIDTH-1:0]  axi_rd_data,
  input  logic                    axi_rd_data_vld,
  input  logic                    axi_rd_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_t state_q, state_d;

  logic [ARID_WIDTH-1:0]   id_q;
  logic [ARADDR_WIDTH-1:0] addr_q;
  logic [7:0]              cnt_q;
  logic [1:0]              size_q;
  logic                    fixed_q;
  logic                    err_q;
  logic [1:0]              region_q;
  logic                    rvalid_q;
  logic                    rlast_q;
  logic [1:0]              rresp_q;
  logic [RDATA_WIDTH-1:0]  rdata_q;

  logic                    ar_hs;
  logic                    r_hs;
  logic                    ar_err;
  logic                    last_beat;
  logic [ARADDR_WIDTH-1:0] step;

  assign ar_hs     = axi.ARVALID && axi.ARREADY;
  assign r_hs      = rvalid_q && axi.RREADY;
  assign ar_err    = (axi.ARSIZE > 3'd2) || (axi.ARBURST >= 3'd3);
  assign last_beat = (cnt_q == 8'd0);
  assign step      = ARADDR_WIDTH'(1) << size_q;

  assign axi.RID       = id_q;
  assign axi.RDATA     = rdata_q;
  assign axi.RRESP     = rresp_q;
  assign axi.RLAST     = rlast_q;
  assign axi.RVALID    = rvalid_q;
  assign axi_rd_addr   = addr_q;
  assign axi_rd_region = region_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode plus the state-decoded strobes (ARREADY, rd_req)
  always_comb begin
    state_d     = state_q;
    axi.ARREADY = 1'b0;
    axi_rd_req  = 1'b0;
    case (state_q)
      S_IDLE: begin
        axi.ARREADY = 1'b1;
        if (ar_hs) state_d = ar_err ? S_RESP : S_REQ;
      end
      S_REQ: begin
        axi_rd_req = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (axi_rd_data_vld) state_d = S_RESP;
      end
      S_RESP: begin
        if (r_hs) begin
          if (last_beat)  state_d = S_IDLE;
          else if (err_q) state_d = S_RESP;
          else            state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Burst context capture, beat address/count stepping and R channel registers
  always_ff @(posedge clk) begin
    if (rst) begin
      id_q     <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
      size_q   <= '0;
      fixed_q  <= 1'b0;
      err_q    <= 1'b0;
      region_q <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ar_hs) begin
            id_q     <= axi.ARID;
            addr_q   <= axi.ARADDR;
            cnt_q    <= axi.ARLEN;
            size_q   <= axi.ARSIZE[1:0];
            fixed_q  <= (axi.ARBURST == 3'd0);
            err_q    <= ar_err;
            region_q <= axi.ARREGION[1:0];
            if (ar_err) begin
              rvalid_q <= 1'b1;
              rresp_q  <= RESP_SLVERR;
              rdata_q  <= '0;
              rlast_q  <= (axi.ARLEN == 8'd0);
            end
          end
        end
        S_WAIT: begin
          if (axi_rd_data_vld) begin
            rdata_q  <= axi_rd_data;
            rresp_q  <= axi_rd_err ? RESP_SLVERR : RESP_OKAY;
            rvalid_q <= 1'b1;
            rlast_q  <= last_beat;
          end
        end
        S_RESP: begin
          if (r_hs) begin
            if (last_beat) begin
              rvalid_q <= 1'b0;
              rlast_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 8'd1;
              if (!fixed_q) addr_q <= addr_q + step;
              // Error bursts have no internal round trip, so the next
              // SLVERR beat is presented back to back.
              if (err_q) begin
                rvalid_q <= 1'b1;
                rlast_q  <= (cnt_q == 8'd1);
              end else begin
                rvalid_q <= 1'b0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_intf.sv
// Scoreboard bench for axi_read_intf: stimulus pushes expected internal
// requests and R beats, a negedge monitor pops and compares them.
module tb_axi_read_intf;
  localparam int IW = 8;
  localparam int AW = 11;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_read_intf_if #(.ARID_WIDTH(IW), .ARADDR_WIDTH(AW), .RDATA_WIDTH(DW)) bus ();

  logic          axi_rd_req;
  logic [AW-1:0] axi_rd_addr;
  logic [1:0]    axi_rd_region;
  logic [DW-1:0] axi_rd_data;
  logic          axi_rd_data_vld;
  logic          axi_rd_err;

  axi_read_intf #(.ARID_WIDTH(IW), .ARADDR_WIDTH(AW), .RDATA_WIDTH(DW)) dut (
    .clk             (clk),
    .rst             (rst),
    .axi             (bus.slave),
    .axi_rd_req      (axi_rd_req),
    .axi_rd_addr     (axi_rd_addr),
    .axi_rd_region   (axi_rd_region),
    .axi_rd_data     (axi_rd_data),
    .axi_rd_data_vld (axi_rd_data_vld),
    .axi_rd_err      (axi_rd_err)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [1:0]    region;
  } req_t;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
  } beat_t;

  req_t  exp_req[$];
  beat_t exp_beat[$];

  int checks = 0;
  int errors = 0;

  // stimulus -> responder / monitor handshakes (sequence counters)
  int rsp_delay  = 0;
  bit rsp_enable = 1'b1;
  int err_seq    = 0;
  int kick_seq   = 0;
  int probe_seq  = 0;
  int probe_kind = 0;
  logic probe_val = 1'b0;
  int timeouts   = 0;

  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
    return 32'hA500_0000 | DW'(a);
  endfunction

  // Internal memory model: answers each request after rsp_delay extra cycles
  initial begin
    bit            pend;
    int            dly;
    logic [AW-1:0] pa;
    int            kick_done;
    int            err_done;
    pend = 1'b0; dly = 0; pa = '0; kick_done = 0; err_done = 0;
    axi_rd_data_vld = 1'b0;
    axi_rd_err      = 1'b0;
    axi_rd_data     = '0;
    forever begin
      @(posedge clk); #1;
      axi_rd_data_vld = 1'b0;
      axi_rd_err      = 1'b0;
      if (pend && (rsp_enable ? (dly == 0) : (kick_seq != kick_done))) begin
        axi_rd_data_vld = 1'b1;
        axi_rd_data     = mem_data(pa);
        if (err_seq != err_done) begin
          axi_rd_err = 1'b1;
          err_done   = err_seq;
        end
        pend      = 1'b0;
        kick_done = kick_seq;
      end else if (pend && rsp_enable) begin
        dly--;
      end
      if (axi_rd_req) begin
        pend = 1'b1;
        pa   = axi_rd_addr;
        dly  = rsp_delay;
      end
    end
  end

  // Monitor: scoreboard pops, stall stability, probes, timeout accounting
  initial begin
    req_t  er;
    req_t  ar;
    beat_t eb;
    beat_t ab;
    beat_t held;
    bit    stall_prev;
    int    probe_done;
    int    timeouts_seen;
    stall_prev = 1'b0; probe_done = 0; timeouts_seen = 0; held = '0;
    forever begin
      @(negedge clk);
      ab = '{id: bus.RID, data: bus.RDATA, resp: bus.RRESP, last: bus.RLAST};
      ar = '{addr: axi_rd_addr, region: axi_rd_region};
      if (!rst) begin
        if (axi_rd_req) begin
          checks++;
          if (exp_req.size() == 0) begin
            errors++;
            $display("FAIL req_unexpected got addr=%h region=%0d, none required", ar.addr, ar.region);
          end else begin
            er = exp_req.pop_front();
            if (ar != er) begin
              errors++;
              $display("FAIL req got addr=%h region=%0d, required addr=%h region=%0d",
                       ar.addr, ar.region, er.addr, er.region);
            end
          end
        end
        if (bus.RVALID && bus.RREADY) begin
          checks++;
          if (exp_beat.size() == 0) begin
            errors++;
            $display("FAIL beat_unexpected got id=%h data=%h resp=%b last=%b", ab.id, ab.data, ab.resp, ab.last);
          end else begin
            eb = exp_beat.pop_front();
            if (ab != eb) begin
              errors++;
              $display("FAIL beat got id=%h data=%h resp=%b last=%b, required id=%h data=%h resp=%b last=%b",
                       ab.id, ab.data, ab.resp, ab.last, eb.id, eb.data, eb.resp, eb.last);
            end
          end
        end
        if (stall_prev) begin
          checks++;
          if (!bus.RVALID || ab != held || axi_rd_req) begin
            errors++;
            $display("FAIL stall got valid=%b data=%h resp=%b last=%b req=%b, required valid=1 data=%h resp=%b last=%b req=0",
                     bus.RVALID, ab.data, ab.resp, ab.last, axi_rd_req, held.data, held.resp, held.last);
          end
        end
        stall_prev = bus.RVALID && !bus.RREADY;
        held       = ab;
      end else begin
        stall_prev = 1'b0;
      end
      if (probe_seq != probe_done) begin
        probe_done = probe_seq;
        checks++;
        case (probe_kind)
          0: if (bus.ARREADY !== probe_val) begin
               errors++;
               $display("FAIL arready got %b, required %b", bus.ARREADY, probe_val);
             end
          1: if (bus.ARREADY !== 1'b1 || bus.RVALID !== 1'b0 || bus.RLAST !== 1'b0 ||
                 bus.RRESP !== 2'b00 || bus.RDATA !== '0 || bus.RID !== '0 ||
                 axi_rd_req !== 1'b0 || axi_rd_addr !== '0 || axi_rd_region !== 2'b00) begin
               errors++;
               $display("FAIL reset_vals got arready=%b rvalid=%b rlast=%b rresp=%b rdata=%h rid=%h req=%b addr=%h region=%0d, required 1 0 0 00 0 0 0 0 0",
                        bus.ARREADY, bus.RVALID, bus.RLAST, bus.RRESP, bus.RDATA, bus.RID,
                        axi_rd_req, axi_rd_addr, axi_rd_region);
             end
          default: if (exp_req.size() != 0 || exp_beat.size() != 0) begin
               errors++;
               $display("FAIL drained got %0d reqs %0d beats pending, required 0 0", exp_req.size(), exp_beat.size());
             end
        endcase
      end
      if (timeouts != timeouts_seen) begin
        timeouts_seen = timeouts;
        checks++;
        errors++;
        $display("FAIL timeout got no DUT progress, required completion (count %0d)", timeouts);
      end
    end
  end

  task automatic push_req(input logic [AW-1:0] a, input logic [1:0] r);
    exp_req.push_back('{addr: a, region: r});
  endtask

  task automatic push_beat(input logic [IW-1:0] id, input logic [DW-1:0] d,
                           input logic [1:0] resp, input logic last);
    exp_beat.push_back('{id: id, data: d, resp: resp, last: last});
  endtask

  task automatic probe(input int kind, input logic val);
    @(posedge clk); #2;
    probe_kind = kind;
    probe_val  = val;
    probe_seq++;
    @(negedge clk); #1;
  endtask

  task automatic send_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [2:0] burst, input logic [3:0] region);
    bit ok;
    @(negedge clk);
    bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len;
    bus.ARSIZE = size; bus.ARBURST = burst; bus.ARREGION = region;
    bus.ARVALID = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.ARREADY) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) @(posedge clk);
    else    timeouts++;
    #1 bus.ARVALID = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (exp_req.size() == 0 && exp_beat.size() == 0 && !bus.RVALID) begin ok = 1'b1; break; end
    end
    if (!ok) timeouts++;
  endtask

  task automatic wait_rvalid();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.RVALID) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) timeouts++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  // Directed stimulus
  initial begin
    bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0;
    bus.ARBURST = '0; bus.ARREGION = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    probe(1, 1'b0);
    probe(0, 1'b1);

    // INCR, 4 beats of 4 bytes, immediate data
    rsp_delay = 0;
    push_req(11'h010, 2'd1); push_req(11'h014, 2'd1); push_req(11'h018, 2'd1); push_req(11'h01C, 2'd1);
    push_beat(8'h3C, 32'hA500_0010, 2'b00, 1'b0);
    push_beat(8'h3C, 32'hA500_0014, 2'b00, 1'b0);
    push_beat(8'h3C, 32'hA500_0018, 2'b00, 1'b0);
    push_beat(8'h3C, 32'hA500_001C, 2'b00, 1'b1);
    send_ar(8'h3C, 11'h010, 8'd3, 3'd2, 3'd1, 4'h1);
    wait_drain();
    probe(0, 1'b1);

    // FIXED, 3 byte beats, slower memory
    rsp_delay = 2;
    for (int i = 0; i < 3; i++) push_req(11'h7F0, 2'd2);
    push_beat(8'h11, 32'hA500_07F0, 2'b00, 1'b0);
    push_beat(8'h11, 32'hA500_07F0, 2'b00, 1'b0);
    push_beat(8'h11, 32'hA500_07F0, 2'b00, 1'b1);
    send_ar(8'h11, 11'h7F0, 8'd2, 3'd0, 3'd0, 4'h2);
    wait_drain();

    // WRAP encoding behaves as INCR and rolls over the address space
    rsp_delay = 1;
    push_req(11'h7FE, 2'd3); push_req(11'h000, 2'd3); push_req(11'h002, 2'd3);
    push_beat(8'h22, 32'hA500_07FE, 2'b00, 1'b0);
    push_beat(8'h22, 32'hA500_0000, 2'b00, 1'b0);
    push_beat(8'h22, 32'hA500_0002, 2'b00, 1'b1);
    send_ar(8'h22, 11'h7FE, 8'd2, 3'd1, 3'd2, 4'hF);
    wait_drain();

    // Backpressure on beat 2, plus an AR attempt while busy
    rsp_delay = 0;
    push_req(11'h100, 2'd0); push_req(11'h104, 2'd0); push_req(11'h108, 2'd0);
    push_beat(8'h55, 32'hA500_0100, 2'b00, 1'b0);
    push_beat(8'h55, 32'hA500_0104, 2'b00, 1'b0);
    push_beat(8'h55, 32'hA500_0108, 2'b00, 1'b1);
    bus.RREADY = 1'b0;
    send_ar(8'h55, 11'h100, 8'd2, 3'd2, 3'd1, 4'h0);
    for (int b = 0; b < 3; b++) begin
      wait_rvalid();
      if (b == 1) begin
        @(posedge clk); #1;
        bus.ARID = 8'hEE; bus.ARADDR = 11'h000; bus.ARLEN = 8'd0;
        bus.ARSIZE = 3'd2; bus.ARBURST = 3'd1; bus.ARVALID = 1'b1;
        probe(0, 1'b0);
        bus.ARVALID = 1'b0;
        repeat (3) @(posedge clk);
      end
      @(posedge clk); #1 bus.RREADY = 1'b1;
      @(posedge clk); #1 bus.RREADY = 1'b0;
    end
    bus.RREADY = 1'b1;
    wait_drain();

    // SLVERR on beat 1 of a normal burst
    err_seq++;
    push_req(11'h020, 2'd0); push_req(11'h024, 2'd0);
    push_beat(8'h77, 32'hA500_0020, 2'b10, 1'b0);
    push_beat(8'h77, 32'hA500_0024, 2'b00, 1'b1);
    send_ar(8'h77, 11'h020, 8'd1, 3'd2, 3'd1, 4'h0);
    wait_drain();

    // Illegal ARSIZE: no requests, SLVERR beats with zero data
    push_beat(8'h99, 32'h0, 2'b10, 1'b0);
    push_beat(8'h99, 32'h0, 2'b10, 1'b1);
    send_ar(8'h99, 11'h040, 8'd1, 3'd3, 3'd1, 4'h0);
    wait_drain();

    // Reserved ARBURST, single beat
    push_beat(8'h9A, 32'h0, 2'b10, 1'b1);
    send_ar(8'h9A, 11'h044, 8'd0, 3'd2, 3'd3, 4'h0);
    wait_drain();

    // Reset while waiting on internal data, late data must be dropped
    rsp_enable = 1'b0;
    push_req(11'h080, 2'd1);
    send_ar(8'hAB, 11'h080, 8'd0, 3'd2, 3'd1, 4'h1);
    begin
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
        if (exp_req.size() == 0) begin ok = 1'b1; break; end
        @(negedge clk);
      end
      if (!ok) timeouts++;
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    kick_seq++;
    repeat (3) @(posedge clk);
    probe(1, 1'b0);
    rsp_enable = 1'b1;
    push_req(11'h084, 2'd2);
    push_beat(8'h5A, 32'hA500_0084, 2'b00, 1'b1);
    send_ar(8'h5A, 11'h084, 8'd0, 3'd2, 3'd1, 4'h2);
    wait_drain();
    probe(2, 1'b0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_read_intf.md
Name: axi_read_intf

Overview:
AXI read-channel slave that pairs with the AXI write-channel slave. It accepts one AR burst at a time and converts each beat into a single-cycle internal read request (address plus 2-bit region) toward FIFO/IRAM/WRAM. It returns the internal read data on the R channel with RID, RRESP and RLAST. Only one burst is outstanding at a time; no read interleaving.

Parameters:
ARID_WIDTH, 8, width of ARID/RID
ARADDR_WIDTH, 11, byte address width
RDATA_WIDTH, 32, data width; only ARSIZE 0..2 are legal

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ARID  in  ARID_WIDTH  read burst ID
ARADDR  in  ARADDR_WIDTH  start byte address
ARLEN  in  8  beats minus 1
ARSIZE  in  3  bytes per beat = 1<<ARSIZE
ARBURST  in  3  0=FIXED, 1=INCR, 2=WRAP (handled as INCR), others reserved
ARREGION  in  4  target region; bits [1:0] used, [3:2] ignored
ARVALID  in  1  AR valid
ARREADY  out  1  AR ready
RID  out  ARID_WIDTH  captured ARID
RDATA  out  RDATA_WIDTH  read data
RRESP  out  2  00 OKAY, 10 SLVERR
RLAST  out  1  last beat
RVALID  out  1  R valid
RREADY  in  1  R ready
axi_rd_req  out  1  one-cycle internal read strobe
axi_rd_addr  out  ARADDR_WIDTH  beat address
axi_rd_region  out  2  target region
axi_rd_data  in  RDATA_WIDTH  returned data
axi_rd_data_vld  in  1  returned data valid, one cycle
axi_rd_err  in  1  error flag, qualified by axi_rd_data_vld

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high. Everything is sampled on the rising clk edge.
- Reset values: ARREADY=1, RVALID=0, RLAST=0, RRESP=00, RDATA=0, RID=0, axi_rd_req=0, axi_rd_addr=0, axi_rd_region=0, FSM=IDLE.
- Reset mid-burst aborts the burst. Any axi_rd_data_vld arriving after reset is ignored.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: ARREADY=1. On ARVALID&ARREADY:
  - capture ID, ADDR, LEN, SIZE, BURST, REGION[1:0];
  - set beat counter cnt=ARLEN;
  - ARREADY=0 from the next cycle;
  - next state is REQ, or RESP for an error burst.
- Error burst: ARSIZE>2, or ARBURST is 3 or >=4.
  - No internal requests are issued.
  - Every beat returns RRESP=10 and RDATA=0, still ARLEN+1 beats, RLAST on the final beat.
- REQ: axi_rd_req=1 for exactly one cycle with the current addr and region. Next state is WAIT.
- WAIT: waits any number of cycles (>=1) for axi_rd_data_vld.
  - On axi_rd_data_vld, register RDATA=axi_rd_data and RRESP = axi_rd_err ? 10 : 00.
  - Also set RVALID=1 and RLAST=(cnt==0). Next state is RESP.
- axi_rd_data_vld outside WAIT is ignored.
- RESP: RVALID and all R fields stay stable until RREADY.
  - On RVALID&RREADY with cnt!=0: decrement cnt, update addr, RVALID=0, go to REQ (or RESP again for an error burst).
  - On RVALID&RREADY with cnt==0: RVALID=0 and RLAST=0; ARREADY=1 in the same cycle as the return to IDLE.
- Minimum beat latency: AR handshake at cycle T gives axi_rd_req at T+1; with data_vld at T+2, RVALID is at T+3.
- Address update:
  - FIXED: the address stays at the start address.
  - INCR/WRAP: addr += (1<<size), modulo 2^ARADDR_WIDTH (wraps silently; no 4KB check).
- No unaligned-address correction: the start address is used as given.
- RID is driven from the captured ID for every beat of the burst.
- ARVALID while busy is not accepted (ARREADY=0); the master holds it.

Test Plan:
- INCR burst: ARID=8'h3C, ARADDR=0x010, ARLEN=3, ARSIZE=2, data returned 1 cycle after each req, RREADY=1 -> axi_rd_addr 0x010/0x014/0x018/0x01C; 4 R beats with RID=3C, RRESP=00; RLAST only on beat 4; ARREADY back to 1 after the last handshake.
- FIXED burst: ARADDR=0x7F0, ARLEN=2, ARSIZE=0 -> 3 requests, all at 0x7F0.
- INCR wrap: ARADDR=0x7FE, ARSIZE=1, ARLEN=2 -> addresses 0x7FE, 0x000, 0x002.
- Backpressure: RREADY=0 for 5 cycles on beat 2 -> RDATA/RRESP/RLAST stable, no new axi_rd_req until the handshake; a second ARVALID during the burst sees ARREADY=0.
- Errors: axi_rd_err=1 on beat 1 of a 2-beat burst -> RRESP 10 then 00. ARSIZE=3, ARLEN=1 -> zero axi_rd_req, 2 beats of RRESP=10, RDATA=0, RLAST on beat 2.
- rst asserted in WAIT, then axi_rd_data_vld=1 -> all outputs at reset values, no RVALID; a new AR is accepted normally.
